// File: rtl/engine_prog_nfa.sv
// engine_prog_nfa: run-time programmable shift-and NFA for one payload-engine channel.
// The pattern lives in a small config table (one entry per NFA state), not in gates.
// Optional feature macro: PAYLOAD_ENGINE_MATCH_OFFSET_EN
//   defined     -> match_offset_o reports the byte offset of the first completed match
//   not defined -> match_offset_o is tied to 0; no offset counter or capture register
`timescale 1ns/1ps

module engine_prog_nfa #(
  parameter int DEPTH    = 34,
  parameter int AW       = 6,
  parameter int OFFSET_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                sod_i,
  input  logic                cfg_we_i,
  input  logic [AW-1:0]       cfg_addr_i,
  input  logic [11:0]         cfg_data_i,
  input  logic                in_valid_i,
  input  logic [7:0]          in_char_i,
  output logic                in_ready_o,
  output logic                match_pulse_o,
  output logic                match_o,
  output logic [OFFSET_W-1:0] match_offset_o
);

  // Config table, one register set per NFA state (all read in parallel every byte)
  logic [DEPTH-1:0] valid_q, last_q, rep_q, nocase_q;
  logic [7:0]       ch_q [DEPTH];

  // NFA state vector and per-byte step logic
  logic [DEPTH-1:0] s_q, s_d, s_cur, s_step, hit, reach;
  logic             accept, complete;
  logic             match_q, match_d, match_cur, pulse_q, pulse_d;
  logic [7:0]       in_fold;
  logic             in_ws;

  function automatic logic [7:0] fold(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
  endfunction

  function automatic logic is_ws(input logic [7:0] c);
    return (c >= 8'h09 && c <= 8'h0D) || (c == 8'h20);
  endfunction

  // A config write stalls the byte stream so no payload byte is dropped
  assign in_ready_o = !cfg_we_i;
  assign accept     = in_valid_i & in_ready_o;
  assign in_fold    = fold(in_char_i);
  assign in_ws      = is_ws(in_char_i);

  // sod and a config write both restart the search; sod also drops the sticky match
  assign s_cur     = (sod_i || cfg_we_i) ? '0 : s_q;
  assign match_cur = sod_i ? 1'b0 : match_q;

  // Table write port; reset invalidates every entry
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q  <= '0;
      last_q   <= '0;
      rep_q    <= '0;
      nocase_q <= '0;
      for (int i = 0; i < DEPTH; i++) ch_q[i] <= '0;
    end else if (cfg_we_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cfg_addr_i == AW'(i)) begin
          valid_q[i]  <= cfg_data_i[11];
          last_q[i]   <= cfg_data_i[10];
          rep_q[i]    <= cfg_data_i[9];
          nocase_q[i] <= cfg_data_i[8];
          ch_q[i]     <= cfg_data_i[7:0];
        end
      end
    end
  end

  // Entries beyond the first last entry are unreachable, so mask them out
  always_comb begin
    reach[0] = 1'b1;
    for (int i = 1; i < DEPTH; i++) reach[i] = reach[i-1] & ~last_q[i-1];
  end

  // Per-state shift-and step; state 0 is always armed (unanchored search)
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_state
    logic eq, prev;
    assign eq = (ch_q[gi] == 8'h00) ? in_ws :
                nocase_q[gi]        ? (in_fold == fold(ch_q[gi])) :
                                      (in_char_i == ch_q[gi]);
    if (gi == 0) begin : g_first
      assign prev = 1'b1;
    end else begin : g_chain
      assign prev = s_cur[gi-1];
    end
    assign hit[gi]    = valid_q[gi] & reach[gi] & eq;
    assign s_step[gi] = hit[gi] & (prev | (rep_q[gi] & s_cur[gi]));
  end

  // Next-state selection and completion detect
  always_comb begin
    s_d      = accept ? s_step : s_cur;
    complete = accept & (|(s_step & last_q));
    pulse_d  = complete;
    match_d  = match_cur | complete;
  end

  // NFA state, pulse and sticky match registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s_q     <= '0;
      pulse_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      pulse_q <= pulse_d;
      match_q <= match_d;
    end
  end

  assign match_pulse_o = pulse_q;
  assign match_o       = match_q;

`ifdef PAYLOAD_ENGINE_MATCH_OFFSET_EN
  localparam logic [OFFSET_W-1:0] CNT_MAX = '1;

  logic [OFFSET_W-1:0] cnt_q, cnt_d, cnt_cur, off_q, off_d;

  // cnt_cur is the 0-based offset of the byte presented this cycle
  assign cnt_cur = sod_i ? '0 : cnt_q;

  // Saturating byte counter and first-match offset capture
  always_comb begin
    cnt_d = cnt_cur;
    if (accept && cnt_cur != CNT_MAX) cnt_d = cnt_cur + OFFSET_W'(1);
    off_d = sod_i ? '0 : off_q;
    if (complete && !match_cur) off_d = cnt_cur;
  end

  // Counter and capture registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      off_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      off_q <= off_d;
    end
  end

  assign match_offset_o = off_q;
`else
  assign match_offset_o = '0;
`endif

endmodule

// File: tb/tb_engine_prog_nfa.sv
// tb_engine_prog_nfa: table-driven bench with an expected-result scoreboard.
// Offset expectations apply when PAYLOAD_ENGINE_MATCH_OFFSET_EN is defined; otherwise 0.
`timescale 1ns/1ps

module tb_engine_prog_nfa;

  localparam int DEPTH = 34;
  localparam int AW    = 6;
  localparam int OW    = 5;   // small counter so saturation is reachable quickly
`ifdef PAYLOAD_ENGINE_MATCH_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  localparam int OP_STEP  = 0;
  localparam int OP_RESET = 1;
  localparam int OP_PROG  = 2;
  localparam int OP_STALL = 3;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          sod_i = 1'b0;
  logic          cfg_we_i = 1'b0;
  logic [AW-1:0] cfg_addr_i = '0;
  logic [11:0]   cfg_data_i = '0;
  logic          in_valid_i = 1'b0;
  logic [7:0]    in_char_i = '0;
  logic          in_ready_o, match_pulse_o, match_o;
  logic [OW-1:0] match_offset_o;

  engine_prog_nfa #(.DEPTH(DEPTH), .AW(AW), .OFFSET_W(OW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .sod_i(sod_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .in_valid_i(in_valid_i), .in_char_i(in_char_i), .in_ready_o(in_ready_o),
    .match_pulse_o(match_pulse_o), .match_o(match_o), .match_offset_o(match_offset_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         op;
    bit         sod;
    bit         vld;
    logic [7:0] ch;
    bit         pulse;
    bit         match;
    int         off;    // -1: offset not checked
  } vec_t;

  typedef struct {
    bit pulse;
    bit match;
    int off;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(int op, bit s, bit v, logic [7:0] c, bit p, bit m, int o);
    vec_t t;
    t.op = op; t.sod = s; t.vld = v; t.ch = c; t.pulse = p; t.match = m; t.off = o;
    vecs.push_back(t);
  endfunction

  function automatic void add_str(bit first_sod, string s, bit m);
    for (int i = 0; i < s.len(); i++)
      add(OP_STEP, first_sod && i == 0, 1'b1, s[i], 1'b0, m, -1);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(bit p, bit m, int o);
    exp_t e;
    e.pulse = p; e.match = m; e.off = o;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs now
  task automatic pop_cmp(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".pulse"}, int'(match_pulse_o), int'(e.pulse));
    chk({tag, ".match"}, int'(match_o), int'(e.match));
    if (e.off >= 0) chk({tag, ".offset"}, int'(match_offset_o), OFF_EN ? e.off : 0);
  endtask

  task automatic do_step(vec_t v);
    sod_i = v.sod; in_valid_i = v.vld; in_char_i = v.ch;
    push_exp(v.pulse, v.match, v.off);
    #1;
    if (v.vld) chk("in_ready", int'(in_ready_o), 1);
    @(posedge clk); #1;
    sod_i = 1'b0; in_valid_i = 1'b0;
    $display("byte sod=%0b vld=%0b ch=%02h -> pulse=%0b match=%0b off=%0d",
             v.sod, v.vld, v.ch, match_pulse_o, match_o, match_offset_o);
    pop_cmp("step");
  endtask

  // Reset with a byte presented: reset must dominate
  task automatic do_reset(vec_t v);
    rst_n_i = 1'b0; sod_i = 1'b0; in_valid_i = 1'b1; in_char_i = v.ch;
    push_exp(1'b0, 1'b0, 0);
    @(posedge clk); #1;
    rst_n_i = 1'b1; in_valid_i = 1'b0;
    $display("reset -> pulse=%0b match=%0b off=%0d", match_pulse_o, match_o, match_offset_o);
    pop_cmp("reset");
  endtask

  task automatic cfg_write(logic [AW-1:0] a, logic [11:0] d, bit v, logic [7:0] c, bit em);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d; in_valid_i = v; in_char_i = c;
    push_exp(1'b0, em, -1);
    #1;
    chk("cfg_in_ready", int'(in_ready_o), 0);
    @(posedge clk); #1;
    cfg_we_i = 1'b0; in_valid_i = 1'b0;
    $display("cfg addr=%0d data=%03h vld=%0b -> pulse=%0b match=%0b", a, d, v, match_pulse_o, match_o);
    pop_cmp("cfg");
  endtask

  // Shared setup: 0:'a', 1:'b', 2:ws+rep, 3:'c'+last, all valid, nocase on
  task automatic do_prog();
    cfg_write(6'd0, 12'h961, 1'b0, 8'h00, match_o);
    cfg_write(6'd1, 12'h962, 1'b0, 8'h00, match_o);
    cfg_write(6'd2, 12'hB00, 1'b0, 8'h00, match_o);
    cfg_write(6'd3, 12'hD63, 1'b0, 8'h00, match_o);
  endtask

  initial begin
    // Reset state and programming
    add(OP_RESET, 0, 1, "c", 0, 0, 0);
    add(OP_PROG,  0, 0, 0,   0, 0, -1);
    // Test 1: "xab  c" -> pulse after 'c', offset 5
    add_str(0, "xab  ", 0);
    add(OP_STEP, 0, 1, "c", 1, 1, 5);
    add(OP_STEP, 0, 0, 0,   0, 1, 5);
    // Test 2: case folding "AB\tC" at offset 3, then "abc" does not match
    add(OP_STEP, 1, 1, "A", 0, 0, 0);
    add_str(0, "B\t", 0);
    add(OP_STEP, 0, 1, "C", 1, 1, 3);
    add_str(0, "ab", 1);
    add(OP_STEP, 0, 1, "c", 0, 1, 3);
    // Test 3: sod between "ab" and "  c"
    add_str(1, "ab", 0);
    add(OP_STEP, 1, 0, 0, 0, 0, 0);
    add_str(0, "  ", 0);
    add(OP_STEP, 0, 1, "c", 0, 0, 0);
    // Test 4: sod together with 'c'; that 'c' is offset 0
    add_str(1, "ab ", 0);
    add(OP_STEP, 1, 1, "c", 0, 0, 0);
    add_str(0, "ab ", 0);
    add(OP_STEP, 0, 1, "c", 1, 1, 4);
    // Counter saturation, then a repeated match re-pulses with the offset held
    add(OP_STEP, 1, 1, "x", 0, 0, 0);
    for (int i = 0; i < 29; i++) add(OP_STEP, 0, 1, "x", 0, 0, -1);
    add_str(0, "ab ", 0);
    add(OP_STEP, 0, 1, "c", 1, 1, 31);
    add(OP_STEP, 0, 1, " ", 0, 1, 31);
    add_str(0, "ab ", 1);
    add(OP_STEP, 0, 1, "c", 1, 1, 31);
    // Test 5: reset mid-pattern, then the cleared table never matches
    add_str(1, "ab ", 0);
    add(OP_RESET, 0, 1, "c", 0, 0, 0);
    add(OP_STEP, 0, 1, "c", 0, 0, 0);
    add_str(0, "ab ", 0);
    add(OP_STEP, 0, 1, "c", 0, 0, 0);
    // Test 6: reprogram, then a stalled byte is taken exactly once
    add(OP_PROG,  0, 0, 0,   0, 0, -1);
    add(OP_STEP,  1, 0, 0,   0, 0, 0);
    add(OP_STALL, 0, 1, "a", 0, 0, -1);
    add_str(0, "ab ", 0);
    add(OP_STEP,  0, 1, "c", 1, 1, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_RESET: do_reset(vecs[i]);
        OP_PROG:  do_prog();
        OP_STALL: cfg_write(6'd3, 12'hD63, 1'b1, vecs[i].ch, vecs[i].match);
        default:  do_step(vecs[i]);
      endcase
    end

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
